instruction_fetch_unit: RTL and testbench

Program-counter and IF/ID stage feeding the combinational instruction memory (16-bit word-addressed ROM, word index = pc[4:1]). Holds the PC, drives it to the memory each cycle, captures the returned instruction and pc+2 into the IF/ID register for decode, and applies stall, redirect (branch/jump) and halt control. One instruction fetched per cycle when not stalled.

---
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: PC/instruction memory path, IF/ID outputs and decode control.
// The fetch unit takes the master side (it drives the memory address and IF/ID);
// the decode/memory environment takes the slave side.
interface instruction_fetch_unit_if;
  // control from decode
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  // instruction memory
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  // IF/ID register and status
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        halted;
  logic [15:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, instr_in,
    output pc_out, ifid_valid, ifid_instr, ifid_pc_plus2, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, instr_in,
    input  pc_out, ifid_valid, ifid_instr, ifid_pc_plus2, halted, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter plus IF/ID register: fetches one instruction per unstalled cycle
// from a combinational ROM, with redirect, stall and halt-opcode control.
// Ports: clk, rst_n (async active-low), bus (master side of instruction_fetch_unit_if).
module instruction_fetch_unit #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111,
  parameter bit          ENABLE_HALT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc_plus2_q, ifid_pc_plus2_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_tgt;
  logic        is_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOOT;
      pc_q            <= PC_RESET;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= 16'h0000;
      ifid_pc_plus2_q <= 16'h0000;
      fetch_count_q   <= 16'h0000;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus2_q <= ifid_pc_plus2_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus2_d = ifid_pc_plus2_q;
    fetch_count_d   = fetch_count_q;

    pc_plus2     = pc_q + 16'd2;                      // wraps FFFE -> 0000
    redirect_tgt = {bus.redirect_pc[15:1], 1'b0};     // targets are halfword aligned
    is_halt      = ENABLE_HALT && (bus.instr_in[15:12] == HALT_OPCODE);

    case (state_q)
      BOOT: begin
        // one settling cycle so the ROM sees PC_RESET before the first capture
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          // redirect wins over stall; the wrong-path slot becomes a bubble
          pc_d         = redirect_tgt;
          ifid_valid_d = 1'b0;
        end else if (!bus.stall) begin
          ifid_instr_d    = bus.instr_in;
          ifid_pc_plus2_d = pc_plus2;
          ifid_valid_d    = 1'b1;
          fetch_count_d   = fetch_count_q + 16'd1;
          if (is_halt) begin
            // halt is still handed to decode, but the PC parks on it
            state_d = HALT;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      HALT: begin
        ifid_valid_d = 1'b0;
        if (bus.redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.pc_out        = pc_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus2 = ifid_pc_plus2_q;
  assign bus.fetch_count   = fetch_count_q;
  assign bus.halted        = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic        v;
    logic [15:0] ins;
    logic [15:0] pp2;
    logic        h;
    logic [15:0] fc;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;

  logic [15:0] mem [16];

  exp_t exp_q[$];
  exp_t exp2_q[$];

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if bus2 ();

  instruction_fetch_unit #(
    .PC_RESET(16'h0000), .HALT_OPCODE(4'hF), .ENABLE_HALT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  instruction_fetch_unit #(
    .PC_RESET(16'h0000), .HALT_OPCODE(4'hF), .ENABLE_HALT(1'b0)
  ) dut_nohalt (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  assign bus.instr_in  = mem[bus.pc_out[4:1]];
  assign bus2.instr_in = mem[bus2.pc_out[4:1]];

  function automatic exp_t mk(input logic [15:0] pc, input logic v, input logic [15:0] ins,
                              input logic [15:0] pp2, input logic h, input logic [15:0] fc);
    exp_t e;
    e.pc = pc; e.v = v; e.ins = ins; e.pp2 = pp2; e.h = h; e.fc = fc;
    return e;
  endfunction

  task automatic cmp(input string nm, input int id, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, a, e);
    end
  endtask

  task automatic check(input string who, input int id, input exp_t a, input exp_t e);
    cmp({who, ".pc_out"}, id, a.pc, e.pc);
    cmp({who, ".ifid_valid"}, id, {15'd0, a.v}, {15'd0, e.v});
    cmp({who, ".ifid_instr"}, id, a.ins, e.ins);
    cmp({who, ".ifid_pc_plus2"}, id, a.pp2, e.pp2);
    cmp({who, ".halted"}, id, {15'd0, a.h}, {15'd0, e.h});
    cmp({who, ".fetch_count"}, id, a.fc, e.fc);
  endtask

  // Monitor for the halt-enabled unit: wakes on clock edges and on reset assertion.
  initial begin : mon1
    int id = 0;
    exp_t a, e;
    forever begin
      @(posedge clk or negedge rst_n);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = mk(bus.pc_out, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_plus2,
               bus.halted, bus.fetch_count);
        check("halt_en", id, a, e);
        id++;
      end
    end
  end

  initial begin : mon2
    int id = 0;
    exp_t a, e;
    forever begin
      @(posedge clk);
      #2;
      if (exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        a = mk(bus2.pc_out, bus2.ifid_valid, bus2.ifid_instr, bus2.ifid_pc_plus2,
               bus2.halted, bus2.fetch_count);
        check("halt_dis", id, a, e);
        id++;
      end
    end
  end

  // Apply one cycle of stimulus at the falling edge and queue the state expected after it.
  task automatic vec(input logic r1, input logic r2, input logic st, input logic rv,
                     input logic [15:0] rp, input exp_t e);
    @(negedge clk);
    rst_n              = r1;
    rst2_n             = r2;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    exp_q.push_back(e);
  endtask

  initial begin : stim
    exp_t rst_e;
    for (int i = 0; i < 16; i++) mem[i] = 16'h2000 + 16'h0011 * 16'(i);
    mem[3] = 16'hF000;
    rst_e = mk(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0000;
    bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 16'h0000;

    // reset state and boot
    vec(0, 0, 0, 0, 16'h0000, rst_e);
    exp2_q.push_back(rst_e);
    vec(1, 0, 0, 0, 16'h0000, rst_e);
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0002, 1, 16'h2000, 16'h0002, 0, 16'd1));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0004, 1, 16'h2011, 16'h0004, 0, 16'd2));
    // stall three cycles
    for (int i = 0; i < 3; i++)
      vec(1, 0, 1, 0, 16'h0000, mk(16'h0004, 1, 16'h2011, 16'h0004, 0, 16'd2));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0006, 1, 16'h2022, 16'h0006, 0, 16'd3));
    // halt word captured, then bubble, then idle (stall ignored)
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0006, 1, 16'hF000, 16'h0008, 1, 16'd4));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0006, 0, 16'hF000, 16'h0008, 1, 16'd4));
    for (int i = 0; i < 10; i++)
      vec(1, 0, 1'(i % 2), 0, 16'h0000, mk(16'h0006, 0, 16'hF000, 16'h0008, 1, 16'd4));
    // leave halt via redirect to 0
    vec(1, 0, 0, 1, 16'h0000, mk(16'h0000, 0, 16'hF000, 16'h0008, 0, 16'd4));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0002, 1, 16'h2000, 16'h0002, 0, 16'd5));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0004, 1, 16'h2011, 16'h0004, 0, 16'd6));
    // redirect overrides stall; odd target aligned down
    vec(1, 0, 1, 1, 16'h0009, mk(16'h0008, 0, 16'h2011, 16'h0004, 0, 16'd6));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h000A, 1, 16'h2044, 16'h000A, 0, 16'd7));
    // PC wrap
    vec(1, 0, 0, 1, 16'hFFFE, mk(16'hFFFE, 0, 16'h2044, 16'h000A, 0, 16'd7));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0000, 1, 16'h20FF, 16'h0000, 0, 16'd8));
    vec(1, 0, 0, 0, 16'h0000, mk(16'h0002, 1, 16'h2000, 16'h0002, 0, 16'd9));
    // asynchronous reset between edges
    vec(0, 0, 0, 0, 16'h0000, rst_e);
    // both units restart; the halt-disabled one runs through F000
    vec(1, 1, 0, 0, 16'h0000, rst_e);
    exp2_q.push_back(rst_e);
    vec(1, 1, 0, 0, 16'h0000, mk(16'h0002, 1, 16'h2000, 16'h0002, 0, 16'd1));
    exp2_q.push_back(mk(16'h0002, 1, 16'h2000, 16'h0002, 0, 16'd1));
    vec(1, 1, 0, 0, 16'h0000, mk(16'h0004, 1, 16'h2011, 16'h0004, 0, 16'd2));
    exp2_q.push_back(mk(16'h0004, 1, 16'h2011, 16'h0004, 0, 16'd2));
    vec(1, 1, 0, 0, 16'h0000, mk(16'h0006, 1, 16'h2022, 16'h0006, 0, 16'd3));
    exp2_q.push_back(mk(16'h0006, 1, 16'h2022, 16'h0006, 0, 16'd3));
    vec(1, 1, 0, 0, 16'h0000, mk(16'h0006, 1, 16'hF000, 16'h0008, 1, 16'd4));
    exp2_q.push_back(mk(16'h0008, 1, 16'hF000, 16'h0008, 0, 16'd4));
    vec(1, 1, 0, 0, 16'h0000, mk(16'h0006, 0, 16'hF000, 16'h0008, 1, 16'd4));
    exp2_q.push_back(mk(16'h000A, 1, 16'h2044, 16'h000A, 0, 16'd5));

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, required 0/0",
               exp_q.size(), exp2_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
